// File: rtl/mac_accumulator.sv
// Unsigned 8x8 shift-add multiply (one bit per cycle) followed by accumulation into an ACC_W-bit register.
// Latency: START at edge k -> ACC/OVF updated and DONE pulsed at edge k+9; next START accepted at edge k+10.
// Backpressure: START is only sampled in IDLE; a START while BUSY is dropped, never queued.
module mac_accumulator #(
  parameter int ACC_W = 20
) (
  input  logic             CLK,
  input  logic             R_N,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             START,
  input  logic             CLR,
  output logic [ACC_W-1:0] ACC,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    mcand;
  logic [7:0]     mplier;
  logic [15:0]    prod;
  logic [2:0]     cnt;
  logic [ACC_W:0] sum;

  // State register.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state: MUL always runs all 8 bits, even when the multiplier is already zero.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_MUL;
      S_MUL:   if (cnt == 3'd7) state_nxt = S_ADD;
      S_ADD:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Carry-extended accumulate sum; the top bit is the overflow carry.
  always_comb begin
    sum = {1'b0, ACC} + {1'b0, ACC_W'(prod)};
  end

  // Shift-add multiplier; operands are captured once at START so later A/B changes are ignored.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            mcand  <= {8'b0, A};
            mplier <= B;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        S_MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Accumulator, sticky overflow and done pulse. CLR in the ADD cycle loads the product
  // instead of zeroing, so a new dot product can start without losing this term.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      ACC  <= '0;
      OVF  <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= (state == S_ADD);
      if (state == S_ADD) begin
        if (CLR) begin
          ACC <= ACC_W'(prod);
          OVF <= 1'b0;
        end else begin
          ACC <= sum[ACC_W-1:0];
          if (sum[ACC_W]) OVF <= 1'b1;
        end
      end else if (CLR) begin
        ACC <= '0;
        OVF <= 1'b0;
      end
    end
  end

  // Busy is a pure decode of the registered state.
  assign BUSY = (state != S_IDLE);

endmodule
